// File: rtl/delay_sweep_ctrl.sv
// Delay-line sweep sequencer. Firmware sets up a code range over Wishbone; the sweep strobes
// the delay line at each code, samples the synchronized comparator and keeps a hit count per code.
//
// state   | meaning
// IDLE    | waiting for START
// LOAD    | drive current code onto the delay line, arm settle timer
// SETTLE  | let the delay line settle
// STROBE  | strobe high
// SAMPLE  | wait for comparator to propagate, then count a hit
// STORE   | write hit count for this code into the result buffer
// ADVANCE | step to next code or finish the sweep
module delay_sweep_ctrl #(
    parameter int CODE_W     = 10,
    parameter int RES_DEPTH  = 64,
    parameter int STB_WIDTH  = 2,
    parameter int SAMPLE_DLY = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_stall_o,
    output logic              wb_err_o,
    output logic [CODE_W-1:0] delay_code_o,
    output logic              stb_o,
    input  logic              cmp_i,
    output logic              busy_o,
    output logic              done_irq_o
);

    localparam int IDX_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [15:0] STB_LOAD = 16'(STB_WIDTH - 1);
    localparam logic [15:0] SMP_LOAD = 16'(SAMPLE_DLY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STROBE,
        S_SAMPLE,
        S_STORE,
        S_ADVANCE
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       rep_q, rep_d;
    logic [15:0]       wait_q, wait_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              irq_q, irq_d;
    logic              stb_q, busy_q;
    logic              res_we;

    logic [CODE_W-1:0] cfg_start_q, cfg_stop_q, cfg_step_q;
    logic [15:0]       cfg_rep_q;
    logic [7:0]        cfg_settle_q;

    logic              ack_q;
    logic [31:0]       dat_q;
    logic              cmp_s1_q, cmp_s2_q;
    logic [15:0]       res_mem [RES_DEPTH];

    logic              wb_req, wb_wr, reg_sel, idle;
    logic [5:0]        reg_idx;
    logic [IDX_W-1:0]  buf_idx;
    logic              start_req, abort_req, cfg_we;
    logic [CODE_W-1:0] step_eff;
    logic [15:0]       rep_eff;
    logic [CODE_W:0]   next_code;
    logic              sweep_end;
    logic [31:0]       status_w, rd_data;
    logic              unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:9], wb_adr_i[1:0], wb_dat_i[31:16]};

    assign wb_req    = wb_cyc_i & wb_stb_i;
    assign wb_wr     = wb_req & wb_we_i;
    assign reg_sel   = ~wb_adr_i[8];
    assign reg_idx   = wb_adr_i[7:2];
    assign buf_idx   = wb_adr_i[2 +: IDX_W];
    assign idle      = (state_q == S_IDLE);
    // ABORT dominates START when both bits are written together
    assign abort_req = wb_wr & reg_sel & (reg_idx == 6'd0) & wb_dat_i[1];
    assign start_req = wb_wr & reg_sel & (reg_idx == 6'd0) & wb_dat_i[0] & ~wb_dat_i[1];
    assign cfg_we    = wb_wr & reg_sel & idle;

    assign step_eff  = (cfg_step_q == '0) ? CODE_W'(1) : cfg_step_q;
    assign rep_eff   = (cfg_rep_q == 16'd0) ? 16'd1 : cfg_rep_q;
    assign next_code = {1'b0, cur_q} + {1'b0, step_eff};
    assign sweep_end = (next_code > {1'b0, cfg_stop_q}) | next_code[CODE_W] | (idx_q == LAST_IDX);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cfg_start_q  <= '0;
            cfg_stop_q   <= '0;
            cfg_step_q   <= '0;
            cfg_rep_q    <= '0;
            cfg_settle_q <= '0;
        end else if (cfg_we) begin
            case (reg_idx)
                6'd2: cfg_start_q  <= wb_dat_i[CODE_W-1:0];
                6'd3: cfg_stop_q   <= wb_dat_i[CODE_W-1:0];
                6'd4: cfg_step_q   <= wb_dat_i[CODE_W-1:0];
                6'd5: cfg_rep_q    <= wb_dat_i[15:0];
                6'd6: cfg_settle_q <= wb_dat_i[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        wait_d    = wait_q;
        code_d    = code_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        irq_d     = 1'b0;
        res_we    = 1'b0;
        if (!idle && abort_req) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        aborted_d = 1'b0;
                        if (cfg_start_q <= cfg_stop_q) begin
                            cur_d   = cfg_start_q;
                            idx_d   = '0;
                            cnt_d   = '0;
                            rep_d   = '0;
                            done_d  = 1'b0;
                            state_d = S_LOAD;
                        end else begin
                            done_d = 1'b1;
                            irq_d  = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    code_d  = cur_q;
                    wait_d  = (cfg_settle_q == 8'd0) ? 16'd0 : {8'd0, cfg_settle_q - 8'd1};
                    state_d = S_SETTLE;
                end
                S_SETTLE: begin
                    if (wait_q == 16'd0) begin
                        wait_d  = STB_LOAD;
                        state_d = S_STROBE;
                    end else begin
                        wait_d = wait_q - 16'd1;
                    end
                end
                S_STROBE: begin
                    if (wait_q == 16'd0) begin
                        wait_d  = SMP_LOAD;
                        state_d = S_SAMPLE;
                    end else begin
                        wait_d = wait_q - 16'd1;
                    end
                end
                S_SAMPLE: begin
                    if (wait_q == 16'd0) begin
                        if (cmp_s2_q && (cnt_q != 16'hFFFF)) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        rep_d = rep_q + 16'd1;
                        if (({1'b0, rep_q} + 17'd1) < {1'b0, rep_eff}) begin
                            wait_d  = STB_LOAD;
                            state_d = S_STROBE;
                        end else begin
                            state_d = S_STORE;
                        end
                    end else begin
                        wait_d = wait_q - 16'd1;
                    end
                end
                S_STORE: begin
                    res_we  = 1'b1;
                    cnt_d   = '0;
                    rep_d   = '0;
                    state_d = S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (sweep_end) begin
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cur_d   = next_code[CODE_W-1:0];
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rep_q     <= '0;
            wait_q    <= '0;
            code_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_q     <= 1'b0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            cmp_s1_q  <= 1'b0;
            cmp_s2_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            wait_q    <= wait_d;
            code_q    <= code_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            irq_q     <= irq_d;
            stb_q     <= (state_d == S_STROBE);
            busy_q    <= (state_d != S_IDLE);
            cmp_s1_q  <= cmp_i;
            cmp_s2_q  <= cmp_s1_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (res_we) begin
            res_mem[idx_q] <= cnt_q;
        end
    end

    always_comb begin
        status_w = '0;
        status_w[0] = busy_q;
        status_w[1] = done_q;
        status_w[2] = aborted_q;
        status_w[16 +: CODE_W] = cur_q;
    end

    always_comb begin
        rd_data = '0;
        if (!reg_sel) begin
            rd_data = {16'd0, res_mem[buf_idx]};
        end else begin
            case (reg_idx)
                6'd1: rd_data = status_w;
                6'd2: rd_data = {{(32-CODE_W){1'b0}}, cfg_start_q};
                6'd3: rd_data = {{(32-CODE_W){1'b0}}, cfg_stop_q};
                6'd4: rd_data = {{(32-CODE_W){1'b0}}, cfg_step_q};
                6'd5: rd_data = {16'd0, cfg_rep_q};
                6'd6: rd_data = {24'd0, cfg_settle_q};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= wb_req;
            dat_q <= (wb_req && !wb_we_i) ? rd_data : 32'd0;
        end
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign wb_stall_o   = 1'b0;
    assign wb_err_o     = 1'b0;
    assign delay_code_o = code_q;
    assign stb_o        = stb_q;
    assign busy_o       = busy_q;
    assign done_irq_o   = irq_q;

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Directed bench for delay_sweep_ctrl; a sweep-level model predicts code order, strobe count
// and per-code hit counts, and a per-cycle monitor checks the bus and strobe behaviour.
`timescale 1ns/1ps
module tb_delay_sweep_ctrl;
    localparam int CODE_W     = 10;
    localparam int RES_DEPTH  = 64;
    localparam int STB_WIDTH  = 2;
    localparam int SAMPLE_DLY = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_cyc, wb_stb, wb_we;
    logic [31:0]       wb_adr, wb_dat_w;
    logic [3:0]        wb_sel;
    logic [31:0]       wb_dat_r;
    logic              wb_ack, wb_stall, wb_err;
    logic [CODE_W-1:0] delay_code;
    logic              stb, cmp, busy, irq;

    int  checks = 0;
    int  errors = 0;
    int  exp_codes[$];
    int  exp_rep = 1;
    int  pulse_cnt = 0;
    int  pulse_base = 0;
    int  irq_cnt = 0;
    int  run_len = 0;
    bit  stb_prev = 0;
    bit  chk_len = 1;
    bit  req_prev = 0;
    bit  cmp_mode = 0;
    bit  cmp_const = 1;
    int  thr = 0;
    int  last_code = 0;

    always #5 clk = ~clk;

    assign cmp = cmp_mode ? (int'(delay_code) >= thr) : cmp_const;

    delay_sweep_ctrl #(
        .CODE_W(CODE_W), .RES_DEPTH(RES_DEPTH), .STB_WIDTH(STB_WIDTH), .SAMPLE_DLY(SAMPLE_DLY)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel), .wb_dat_o(wb_dat_r),
        .wb_ack_o(wb_ack), .wb_stall_o(wb_stall), .wb_err_o(wb_err),
        .delay_code_o(delay_code), .stb_o(stb), .cmp_i(cmp), .busy_o(busy), .done_irq_o(irq)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) req_prev <= wb_cyc & wb_stb & ~rst;

    always @(negedge clk) begin
        int p;
        chk("ack_latency", wb_ack, req_prev);
        chk("stall_err", {wb_stall, wb_err}, 0);
        if (stb) chk("stb_only_when_busy", busy, 1);
        if (stb && !stb_prev) begin
            p = (pulse_cnt - pulse_base) / exp_rep;
            if (p < exp_codes.size()) chk("stb_code", delay_code, exp_codes[p]);
            else chk("stb_extra_pulse", pulse_cnt - pulse_base, exp_codes.size() * exp_rep);
            pulse_cnt++;
            run_len = 1;
        end else if (stb) begin
            run_len++;
        end
        if (!stb && stb_prev && chk_len) chk("stb_width", run_len, STB_WIDTH);
        if (irq) begin
            irq_cnt++;
            chk("irq_when_idle", busy, 0);
        end
        stb_prev = stb;
    end

    task automatic wb_write(input int adr, input int dat);
        wb_cyc = 1; wb_stb = 1; wb_we = 1;
        wb_adr = 32'(adr); wb_dat_w = 32'(dat);
        @(negedge clk);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic wb_read(input int adr, output int dat);
        wb_cyc = 1; wb_stb = 1; wb_we = 0;
        wb_adr = 32'(adr);
        @(negedge clk);
        dat = int'(wb_dat_r);
        wb_cyc = 0; wb_stb = 0;
    endtask

    task automatic build_model(input int start, input int stop, input int step, input int rep);
        int c, n, s;
        exp_codes.delete();
        s = (step == 0) ? 1 : step;
        exp_rep = (rep == 0) ? 1 : rep;
        if (start <= stop) begin
            c = start;
            forever begin
                exp_codes.push_back(c);
                n = c + s;
                if (exp_codes.size() == RES_DEPTH || n > stop || n > 1023) break;
                c = n;
            end
        end
        pulse_base = pulse_cnt;
    endtask

    function automatic int exp_hits(input int code);
        bit hit;
        hit = cmp_mode ? (code >= thr) : cmp_const;
        return hit ? exp_rep : 0;
    endfunction

    task automatic config_regs(input int start, input int stop, input int step, input int rep,
                               input int settle);
        wb_write('h08, start);
        wb_write('h0C, stop);
        wb_write('h10, step);
        wb_write('h14, rep);
        wb_write('h18, settle);
    endtask

    task automatic run_sweep(input int start, input int stop, input int step, input int rep,
                             input int settle, input bit collide);
        int ib, n, d;
        config_regs(start, stop, step, rep, settle);
        build_model(start, stop, step, rep);
        ib = irq_cnt;
        wb_write('h00, 1);
        if (collide) begin
            repeat (3) @(negedge clk);
            wb_write('h0C, start);
            wb_write('h00, 1);
        end
        for (n = 0; n < 20000 && irq_cnt == ib; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("sweep_irq_count", irq_cnt - ib, 1);
        chk("sweep_busy_clear", busy, 0);
        chk("sweep_pulses", pulse_cnt - pulse_base, exp_codes.size() * exp_rep);
        last_code = exp_codes[exp_codes.size() - 1];
        wb_read('h04, d);
        chk("sweep_status", d, 2 | (last_code << 16));
        for (int i = 0; i < exp_codes.size(); i++) begin
            wb_read('h100 + 4 * i, d);
            chk("sweep_buf", d, exp_hits(exp_codes[i]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, ib, n;
        int thr_exp[5] = '{0, 0, 3, 3, 3};
        rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_w = '0; wb_sel = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_code", delay_code, 0);
        chk("rst_outs", {stb, busy, irq, wb_ack}, 0);
        rst = 0;
        @(negedge clk);
        wb_read('h04, d);   chk("rst_status", d, 0);
        wb_read('h08, d);   chk("rst_code_start", d, 0);

        // register read/write
        wb_write('h08, 5);
        wb_write('h0C, 9);
        wb_write('h10, 2);
        wb_read('h08, d);   chk("rd_code_start", d, 5);
        wb_read('h0C, d);   chk("rd_code_stop", d, 9);
        wb_read('h10, d);   chk("rd_step", d, 2);
        wb_read('h00, d);   chk("rd_ctrl_zero", d, 0);
        wb_read('h1C, d);   chk("rd_unmapped", d, 0);

        // basic sweep, comparator always high
        cmp_mode = 0; cmp_const = 1;
        run_sweep(0, 3, 1, 4, 2, 0);
        chk("basic_model_len", exp_codes.size(), 4);
        wb_read('h100 + 4 * 2, d); chk("basic_buf2_lit", d, 4);

        // comparator threshold at code 20
        cmp_mode = 1; thr = 20;
        run_sweep(16, 24, 2, 3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            wb_read('h100 + 4 * i, d);
            chk("thr_buf_lit", d, thr_exp[i]);
        end

        // STEP=0 behaves as 1, REPEAT=0 behaves as 1
        cmp_mode = 0; cmp_const = 1;
        run_sweep(0, 3, 0, 0, 0, 0);
        chk("step0_model_len", exp_codes.size(), 4);

        // top-of-range step overflow
        run_sweep(1020, 1023, 3, 2, 0, 0);
        chk("top_model_len", exp_codes.size(), 2);
        chk("top_model_last", exp_codes[1], 1023);
        chk("top_code_held", delay_code, 1023);

        // long range stops at buffer end
        run_sweep(0, 200, 1, 1, 0, 0);
        chk("long_model_len", exp_codes.size(), 64);
        wb_read('h04, d);   chk("long_status_lit", d, 2 | (63 << 16));

        // START > STOP: immediate DONE, no strobes
        wb_write('h08, 10);
        wb_write('h0C, 5);
        exp_codes.delete();
        pulse_base = pulse_cnt;
        ib = irq_cnt;
        wb_write('h00, 1);
        chk("empty_irq_now", irq, 1);
        repeat (5) @(negedge clk);
        chk("empty_irq_count", irq_cnt - ib, 1);
        chk("empty_pulses", pulse_cnt - pulse_base, 0);
        wb_read('h04, d);   chk("empty_status", d, 2 | (last_code << 16));

        // config write and START while busy are ignored
        run_sweep(0, 3, 1, 4, 2, 1);
        wb_read('h0C, d);   chk("busy_write_ignored", d, 3);

        // ABORT during strobe
        config_regs(0, 3, 1, 4, 2);
        build_model(0, 3, 1, 4);
        ib = irq_cnt;
        wb_write('h00, 1);
        for (n = 0; n < 200 && !stb; n++) @(negedge clk);
        chk("abort_saw_stb", stb, 1);
        chk_len = 0;
        wb_write('h00, 2);
        chk("abort_stb_low", stb, 0);
        chk("abort_busy_low", busy, 0);
        repeat (5) @(negedge clk);
        chk_len = 1;
        chk("abort_no_irq", irq_cnt - ib, 0);
        wb_read('h04, d);   chk("abort_status", d, 'h4);

        // START and ABORT together: stays idle
        exp_codes.delete();
        pulse_base = pulse_cnt;
        ib = irq_cnt;
        wb_write('h00, 3);
        chk("both_busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("both_pulses", pulse_cnt - pulse_base, 0);
        chk("both_irq", irq_cnt - ib, 0);
        wb_read('h04, d);   chk("both_status", d, 'h4);

        // reset while sampling
        config_regs(5, 8, 1, 4, 2);
        build_model(5, 8, 1, 4);
        wb_write('h00, 1);
        for (n = 0; n < 200 && !stb; n++) @(negedge clk);
        for (n = 0; n < 20 && stb; n++) @(negedge clk);
        @(negedge clk);
        chk("rst_mid_code_before", delay_code, 5);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_code", delay_code, 0);
        chk("rst_mid_outs", {stb, busy, irq}, 0);
        rst = 0;
        @(negedge clk);
        wb_read('h04, d);   chk("rst_mid_status", d, 0);
        run_sweep(0, 3, 1, 4, 2, 0);
        wb_read('h100, d);  chk("rst_mid_buf0_lit", d, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
